// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one BRAM between two requesters.
// A granted access keeps mem_en high until the memory's READY pulse or a timeout.
module bram_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          RST,

  input  logic          m0_req,
  input  logic [3:0]    m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic [3:0]    m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do,
  input  logic          mem_ready
);

  localparam bit TO_EN = (TIMEOUT > 0);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic          owner;
  logic          ptr;
  logic          grant;
  logic          any_req;
  logic          timeout_hit;
  logic [3:0]    lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          err0;
  logic          err1;

  // The pointer only breaks ties; a lone requester is always granted.
  assign any_req     = m0_req | m1_req;
  assign grant       = (m0_req & m1_req) ? ptr : m1_req;
  assign timeout_hit = TO_EN && (cnt == TO_LAST) && !mem_ready;

  assign mem_addr = lat_addr;
  assign mem_di   = lat_wdata;
  assign m0_rdata = rdata0;
  assign m1_rdata = rdata1;
  assign m0_err   = err0;
  assign m1_err   = err1;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_en   = 1'b0;
    mem_we   = 4'h0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nx = BUSY;
      end
      BUSY: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        if (mem_ready || timeout_hit) state_nx = ACK;
      end
      ACK: begin
        m0_ack   = !owner;
        m1_ack   = owner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Requester inputs are captured once at grant; the memory sees only the latched copy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      owner     <= 1'b0;
      ptr       <= 1'b0;
      lat_we    <= 4'h0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant;
            ptr       <= ~grant;
            lat_we    <= grant ? m1_we    : m0_we;
            lat_addr  <= grant ? m1_addr  : m0_addr;
            lat_wdata <= grant ? m1_wdata : m0_wdata;
            cnt       <= '0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            cnt <= '0;
            if (owner) begin
              rdata1 <= mem_do;
              err1   <= 1'b0;
            end else begin
              rdata0 <= mem_do;
              err0   <= 1'b0;
            end
          end else if (timeout_hit) begin
            cnt <= '0;
            if (owner) begin
              rdata1 <= '0;
              err1   <= 1'b1;
            end else begin
              rdata0 <= '0;
              err0   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter: a 12-cycle BRAM model on the main instance
// and a fast, killable memory on a second instance built with TIMEOUT=8.
module tb_bram_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST;

  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_ready;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_di, mem_do;

  logic        t_m0_req, t_m1_req;
  logic [3:0]  t_m0_we, t_m1_we;
  logic [31:0] t_m0_addr, t_m1_addr, t_m0_wdata, t_m1_wdata;
  logic        t_m0_ack, t_m1_ack, t_m0_err, t_m1_err;
  logic [31:0] t_m0_rdata, t_m1_rdata;
  logic        t_mem_en, t_mem_ready;
  logic [3:0]  t_mem_we;
  logic [31:0] t_mem_addr, t_mem_di, t_mem_do;
  logic        t_dead;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  bram_rr_arbiter u_dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_do(mem_do), .mem_ready(mem_ready)
  );

  bram_rr_arbiter #(.TIMEOUT(8)) u_to (
    .CLK(CLK), .RST(RST),
    .m0_req(t_m0_req), .m0_we(t_m0_we), .m0_addr(t_m0_addr), .m0_wdata(t_m0_wdata),
    .m0_ack(t_m0_ack), .m0_err(t_m0_err), .m0_rdata(t_m0_rdata),
    .m1_req(t_m1_req), .m1_we(t_m1_we), .m1_addr(t_m1_addr), .m1_wdata(t_m1_wdata),
    .m1_ack(t_m1_ack), .m1_err(t_m1_err), .m1_rdata(t_m1_rdata),
    .mem_en(t_mem_en), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_di(t_mem_di),
    .mem_do(t_mem_do), .mem_ready(t_mem_ready)
  );

  // Standard BRAM: READY in the 12th enabled cycle, read word sampled before any write lands.
  logic [31:0] mem [0:1023];
  int          mcnt;
  logic [31:0] mdo;

  assign mem_ready = mem_en && (mcnt == 11);
  assign mem_do    = mdo;

  always @(posedge CLK) begin
    if (RST || !mem_en) begin
      mcnt <= 0;
    end else begin
      mcnt <= (mcnt == 11) ? 0 : mcnt + 1;
      if (mcnt == 0) mdo <= mem[mem_addr[9:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_di[8*b +: 8];
    end
  end

  int tcnt;
  assign t_mem_ready = t_mem_en && !t_dead && (tcnt == 2);
  assign t_mem_do    = {16'hC0DE, t_mem_addr[15:0]};

  always @(posedge CLK) begin
    if (RST || !t_mem_en) tcnt <= 0;
    else                  tcnt <= tcnt + 1;
  end

  task automatic run_access(input bit port, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat, output int en_cnt,
                            output logic [31:0] rd, output logic er, output bit other_ack);
    lat = -1; en_cnt = 0; rd = '0; er = 1'b0; other_ack = 1'b0;
    if (!port) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
    for (int c = 1; c <= 60; c++) begin
      @(posedge CLK); #1;
      if (mem_en) en_cnt++;
      if (port ? m0_ack : m1_ack) other_ack = 1'b1;
      if (port ? m1_ack : m0_ack) begin
        lat = c;
        rd  = port ? m1_rdata : m0_rdata;
        er  = port ? m1_err : m0_err;
        break;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic run_t_access(input logic [31:0] addr, output int lat, output int en_cnt,
                              output logic [31:0] rd, output logic er, output int bus_bad);
    lat = -1; en_cnt = 0; rd = '0; er = 1'b0; bus_bad = 0;
    t_m0_req = 1'b1; t_m0_we = 4'h0; t_m0_addr = addr; t_m0_wdata = 32'h5A5A5A5A;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
      if (t_mem_en) begin
        en_cnt++;
        if (t_mem_addr !== addr || t_mem_di !== 32'h5A5A5A5A || t_mem_we !== 4'h0) bus_bad++;
      end
      if (t_m0_ack) begin
        lat = c; rd = t_m0_rdata; er = t_m0_err;
        break;
      end
    end
    t_m0_req = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_en: got %b want 0", mem_en); end
    total++; if (mem_we !== 4'h0) begin bad++; $display("[TB] FAIL reset_mem_we: got %h want 0", mem_we); end
    total++; if ({mem_addr, mem_di} !== 64'h0) begin bad++; $display("[TB] FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_di}); end
    total++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'h0) begin bad++; $display("[TB] FAIL reset_ack_err: got %b want 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    total++; if ({m0_rdata, m1_rdata} !== 64'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_single_read;
    int lat, en_cnt; logic [31:0] rd; logic er; bit oth;
    mem[5] <= 32'hDEADBEEF;
    run_access(1'b0, 4'h0, 32'd5, 32'h0, lat, en_cnt, rd, er, oth);
    total++; if (lat !== 13) begin bad++; $display("[TB] FAIL read_latency: got %0d want 13", lat); end
    total++; if (en_cnt !== 12) begin bad++; $display("[TB] FAIL read_en_cycles: got %0d want 12", en_cnt); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL read_rdata: got %h want deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("[TB] FAIL read_err: got %b want 0", er); end
    total++; if (oth !== 1'b0) begin bad++; $display("[TB] FAIL read_other_ack: got %b want 0", oth); end
    total++; if (m0_ack !== 1'b0) begin bad++; $display("[TB] FAIL read_ack_pulse: got %b want 0", m0_ack); end
  endtask

  task automatic test_write_readback;
    int lat, en_cnt; logic [31:0] rd; logic er; bit oth;
    mem[3] <= 32'hAAAAAAAA;
    run_access(1'b1, 4'b0011, 32'd3, 32'h12345678, lat, en_cnt, rd, er, oth);
    total++; if (rd !== 32'hAAAAAAAA) begin bad++; $display("[TB] FAIL write_prev_word: got %h want aaaaaaaa", rd); end
    total++; if (lat !== 13 || er !== 1'b0) begin bad++; $display("[TB] FAIL write_ack: got lat=%0d err=%b want lat=13 err=0", lat, er); end
    run_access(1'b1, 4'h0, 32'd3, 32'h0, lat, en_cnt, rd, er, oth);
    total++; if (rd !== 32'hAAAA5678) begin bad++; $display("[TB] FAIL readback: got %h want aaaa5678", rd); end
    total++; if (oth !== 1'b0) begin bad++; $display("[TB] FAIL readback_other_ack: got %b want 0", oth); end
    repeat (3) @(posedge CLK);
    #1;
    total++; if (m1_rdata !== 32'hAAAA5678 || m0_rdata !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL rdata_hold: got m0=%h m1=%h want deadbeef aaaa5678", m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int ord [8];
    int nack = 0, n0 = 0, n1 = 0, overlap = 0, low_run = 0, gap_cnt = 0, gap_bad = 0, rd_bad = 0;
    bit seen_en = 1'b0;
    RST = 1'b1; @(posedge CLK); #1; RST = 1'b0;
    mem[20] <= 32'h20202020;
    mem[21] <= 32'h21212121;
    m0_we = 4'h0; m0_addr = 32'd20; m1_we = 4'h0; m1_addr = 32'd21;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge CLK); #1;
      if (m0_ack && m1_ack) overlap++;
      // ACK and IDLE each keep mem_en low, so every gap is two cycles.
      if (mem_en) begin
        if (seen_en && low_run > 0) begin
          gap_cnt++;
          if (low_run != 2) gap_bad++;
        end
        low_run = 0; seen_en = 1'b1;
      end else if (seen_en) begin
        low_run++;
      end
      if (m0_ack) begin
        if (nack < 8) ord[nack] = 0;
        nack++; n0++;
        if (m0_rdata !== 32'h20202020) rd_bad++;
        if (n0 == 4) m0_req = 1'b0;
      end
      if (m1_ack) begin
        if (nack < 8) ord[nack] = 1;
        nack++; n1++;
        if (m1_rdata !== 32'h21212121) rd_bad++;
        if (n1 == 4) m1_req = 1'b0;
      end
      if (nack >= 8) break;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge CLK); #1;
    total++; if (nack !== 8) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 8", nack); end
    for (int i = 0; i < 8 && i < nack; i++) begin
      total++; if (ord[i] !== (i % 2)) begin bad++; $display("[TB] FAIL b2b_order[%0d]: got port %0d want port %0d", i, ord[i], i % 2); end
    end
    total++; if (overlap !== 0) begin bad++; $display("[TB] FAIL b2b_overlap: got %0d want 0", overlap); end
    total++; if (gap_cnt !== 7 || gap_bad !== 0) begin bad++; $display("[TB] FAIL b2b_gaps: got gaps=%0d wrong=%0d want 7 and 0", gap_cnt, gap_bad); end
    total++; if (rd_bad !== 0) begin bad++; $display("[TB] FAIL b2b_rdata: got %0d wrong want 0", rd_bad); end
  endtask

  task automatic test_input_stability;
    int busy = 0, stab_bad = 0;
    bit acked = 1'b0;
    logic ack_en = 1'b1;
    logic [3:0] ack_we = 4'hF;
    m0_req = 1'b1; m0_we = 4'hF; m0_addr = 32'd9; m0_wdata = 32'h11111111;
    for (int c = 1; c <= 60; c++) begin
      @(posedge CLK); #1;
      if (m0_ack) begin
        acked = 1'b1; m0_req = 1'b0; ack_en = mem_en; ack_we = mem_we;
        break;
      end
      if (mem_en) begin
        busy++;
        if (mem_addr !== 32'd9 || mem_di !== 32'h11111111 || mem_we !== 4'hF) stab_bad++;
      end
      m0_addr = $urandom; m0_wdata = $urandom; m0_we = 4'($urandom);
    end
    m0_req = 1'b0; m0_we = 4'h0; m0_addr = '0; m0_wdata = '0;
    @(posedge CLK); #1;
    total++; if (acked !== 1'b1 || busy !== 12) begin bad++; $display("[TB] FAIL stable_access: got ack=%b busy=%0d want 1 and 12", acked, busy); end
    total++; if (stab_bad !== 0) begin bad++; $display("[TB] FAIL stable_bus: got %0d changed cycles want 0", stab_bad); end
    total++; if (ack_en !== 1'b0 || ack_we !== 4'h0) begin bad++; $display("[TB] FAIL ack_mem_idle: got en=%b we=%h want 0 0", ack_en, ack_we); end
    total++; if (mem[9] !== 32'h11111111) begin bad++; $display("[TB] FAIL stable_written: got %h want 11111111", mem[9]); end
  endtask

  task automatic test_timeout;
    int lat, en_cnt, bus_bad; logic [31:0] rd; logic er;
    t_dead = 1'b0;
    run_t_access(32'd2, lat, en_cnt, rd, er, bus_bad);
    total++; if (lat !== 4 || rd !== 32'hC0DE0002 || er !== 1'b0) begin
      bad++; $display("[TB] FAIL to_normal: got lat=%0d rd=%h err=%b want 4 c0de0002 0", lat, rd, er);
    end
    t_dead = 1'b1;
    run_t_access(32'd4, lat, en_cnt, rd, er, bus_bad);
    total++; if (lat !== 9 || en_cnt !== 8) begin bad++; $display("[TB] FAIL to_latency: got lat=%0d en=%0d want 9 8", lat, en_cnt); end
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL to_err: got err=%b rd=%h want 1 0", er, rd); end
    t_dead = 1'b0;
    run_t_access(32'd6, lat, en_cnt, rd, er, bus_bad);
    total++; if (lat !== 4 || rd !== 32'hC0DE0006 || er !== 1'b0) begin
      bad++; $display("[TB] FAIL to_recover: got lat=%0d rd=%h err=%b want 4 c0de0006 0", lat, rd, er);
    end
    total++; if (bus_bad !== 0) begin bad++; $display("[TB] FAIL to_bus: got %0d wrong want 0", bus_bad); end
    total++; if ({t_m1_ack, t_m1_err, t_m1_rdata} !== 34'h0) begin
      bad++; $display("[TB] FAIL to_port1_quiet: got %h want 0", {t_m1_ack, t_m1_err, t_m1_rdata});
    end
  endtask

  task automatic test_reset_mid_access;
    int first = -1, lat0 = -1, acks_in_reset = 0;
    bit got0 = 1'b0, got1 = 1'b0;
    logic [31:0] rd0 = '0;
    logic en_before = 1'b0;
    // The m0 grant leaves the pointer at port 1, so a surviving pointer would favour m1 below.
    m0_req = 1'b1; m0_we = 4'h0; m0_addr = 32'd5;
    repeat (6) begin
      @(posedge CLK); #1;
    end
    en_before = mem_en;
    RST = 1'b1; m0_req = 1'b0;
    @(posedge CLK); #1;
    total++; if (en_before !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy: got en=%b want 1", en_before); end
    total++; if (mem_en !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_release: got en=%b ack=%b%b want 0 00", mem_en, m0_ack, m1_ack);
    end
    RST = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (m0_ack || m1_ack) acks_in_reset++;
    end
    total++; if (acks_in_reset !== 0) begin bad++; $display("[TB] FAIL midrst_no_ack: got %0d want 0", acks_in_reset); end
    m0_addr = 32'd5; m1_addr = 32'd21; m1_we = 4'h0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge CLK); #1;
      if (m0_ack) begin
        if (first < 0) first = 0;
        got0 = 1'b1; lat0 = c; rd0 = m0_rdata; m0_req = 1'b0;
      end
      if (m1_ack) begin
        if (first < 0) first = 1;
        got1 = 1'b1; m1_req = 1'b0;
      end
      if (got0 && got1) break;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge CLK); #1;
    total++; if (first !== 0) begin bad++; $display("[TB] FAIL midrst_pointer: got first port %0d want 0", first); end
    total++; if (lat0 !== 13 || rd0 !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL midrst_reread: got lat=%0d rd=%h want 13 deadbeef", lat0, rd0);
    end
    total++; if (got1 !== 1'b1) begin bad++; $display("[TB] FAIL midrst_m1_done: got %b want 1", got1); end
  endtask

  initial begin
    RST = 1'b1;
    m0_req = 1'b0; m0_we = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 4'h0; m1_addr = '0; m1_wdata = '0;
    t_m0_req = 1'b0; t_m0_we = 4'h0; t_m0_addr = '0; t_m0_wdata = '0;
    t_m1_req = 1'b0; t_m1_we = 4'h0; t_m1_addr = '0; t_m1_wdata = '0;
    t_dead = 1'b0;
    test_reset;
    test_single_read;
    test_write_readback;
    test_back_to_back;
    test_input_stability;
    test_timeout;
    test_reset_mid_access;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
